// File: rtl/cpri_tx_gen.sv
// cpri_tx_gen - CPRI transmit framer: 2-block ping-pong IQ buffer feeding 99-word write bursts
// (3 header words followed by 96 payload words).
module cpri_tx_gen #(
  parameter int          DATA_WIDTH = 64,
  parameter int          BLK_WORDS  = 96,
  parameter int          HDR_WORDS  = 3,
  parameter logic [31:0] SYNC_WORD  = 32'h5A5AC3C3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tx_enable,
  input  logic                  i_tvalid,
  output logic                  o_tready,
  input  logic [DATA_WIDTH-1:0] i_iq_tx_data,
  input  logic                  i_tlast,
  input  logic [31:0]           i_hdr_info,
  input  logic                  i_cpri_rdy,
  output logic                  o_cpri_wen,
  output logic [6:0]            o_cpri_waddr,
  output logic [DATA_WIDTH-1:0] o_cpri_wdata,
  output logic                  o_cpri_wlast,
  output logic [15:0]           o_blk_cnt,
  output logic                  o_len_err
);

  localparam int          IW        = $clog2(BLK_WORDS);
  localparam logic [IW-1:0] LAST_W  = IW'(BLK_WORDS - 1);
  localparam logic [6:0]  LAST_ADDR = 7'(HDR_WORDS + BLK_WORDS - 1);
  localparam logic [6:0]  HDR_LAST  = 7'(HDR_WORDS - 1);
  localparam logic [6:0]  RD_FIRST  = 7'(HDR_WORDS - 2);
  localparam logic [6:0]  RD_LAST   = 7'(HDR_WORDS - 2 + BLK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t                state, nxt_state;
  logic [DATA_WIDTH-1:0] mem [2][BLK_WORDS];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [IW-1:0]         wcnt;
  logic                  wr_bank, rd_bank;
  logic [1:0]            full_cnt, full_nxt;
  logic [15:0]           blk_cnt;
  logic [31:0]           hdr_q;

  logic                  accept, blk_close, burst_done, go, rd_en;
  logic [6:0]            rd_addr;
  logic [IW-1:0]         rd_idx;
  logic                  nxt_wen, nxt_wlast;
  logic [6:0]            nxt_waddr;
  logic [DATA_WIDTH-1:0] nxt_wdata;

  assign accept     = i_tvalid & o_tready;
  assign blk_close  = accept && (wcnt == LAST_W);
  assign burst_done = (state == PAY) && (o_cpri_waddr == LAST_ADDR);
  assign go         = (state == IDLE) && i_tx_enable && i_cpri_rdy && (full_cnt != 2'd0);
  assign o_blk_cnt  = blk_cnt;

  // Payload read runs one word ahead of the output address so rd_q is ready when waddr reaches it.
  assign rd_en   = (state != IDLE) && (o_cpri_waddr >= RD_FIRST) && (o_cpri_waddr <= RD_LAST);
  assign rd_addr = o_cpri_waddr - RD_FIRST;
  assign rd_idx  = rd_addr[IW-1:0];

  always_comb begin
    full_nxt = full_cnt;
    case ({blk_close, burst_done})
      2'b10:   full_nxt = full_cnt + 2'd1;
      2'b01:   full_nxt = full_cnt - 2'd1;
      default: full_nxt = full_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_bank][wcnt] <= i_iq_tx_data;
    if (rd_en)  rd_q <= mem[rd_bank][rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full_cnt  <= 2'd0;
      o_tready  <= 1'b1;
      o_len_err <= 1'b0;
      blk_cnt   <= 16'd0;
      hdr_q     <= 32'd0;
    end else begin
      o_len_err <= accept && (i_tlast != (wcnt == LAST_W));
      if (accept) begin
        wcnt <= blk_close ? '0 : wcnt + 1'b1;
        if (blk_close) wr_bank <= ~wr_bank;
      end
      full_cnt <= full_nxt;
      o_tready <= (full_nxt < 2'd2);
      if (burst_done) begin
        rd_bank <= ~rd_bank;
        blk_cnt <= blk_cnt + 16'd1;
      end
      if (go) hdr_q <= i_hdr_info;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      o_cpri_wen   <= 1'b0;
      o_cpri_waddr <= 7'd0;
      o_cpri_wdata <= '0;
      o_cpri_wlast <= 1'b0;
    end else begin
      state        <= nxt_state;
      o_cpri_wen   <= nxt_wen;
      o_cpri_waddr <= nxt_waddr;
      o_cpri_wdata <= nxt_wdata;
      o_cpri_wlast <= nxt_wlast;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_wen   = 1'b0;
    nxt_waddr = 7'd0;
    nxt_wdata = '0;
    nxt_wlast = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          nxt_state = HDR;
          nxt_wen   = 1'b1;
          nxt_wdata = DATA_WIDTH'({SYNC_WORD, 16'd0, blk_cnt});
        end
      end
      HDR: begin
        nxt_wen   = 1'b1;
        nxt_waddr = o_cpri_waddr + 7'd1;
        if (o_cpri_waddr == HDR_LAST) begin
          nxt_state = PAY;
          nxt_wdata = rd_q;
        end else if (o_cpri_waddr == 7'd0) begin
          nxt_wdata = DATA_WIDTH'({32'd0, hdr_q});
        end
      end
      PAY: begin
        // Completion cycle returns to IDLE with all outputs low, giving the mandatory idle gap.
        if (o_cpri_waddr == LAST_ADDR) begin
          nxt_state = IDLE;
        end else begin
          nxt_wen   = 1'b1;
          nxt_waddr = o_cpri_waddr + 7'd1;
          nxt_wdata = rd_q;
          nxt_wlast = (o_cpri_waddr == LAST_ADDR - 7'd1);
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpri_tx_gen.sv
// tb_cpri_tx_gen - randomized bench for cpri_tx_gen checked every cycle against a queue-based
// block/burst model, plus literal expectations for the directed scenarios.
module tb_cpri_tx_gen;

  localparam logic [31:0] SYNC = 32'h5A5AC3C3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_enable = 1'b0, tvalid = 1'b0, tlast = 1'b0, cpri_rdy = 1'b0;
  logic [63:0] iq_data = 64'd0;
  logic [31:0] hdr_info = 32'd0;
  logic        tready, wen, wlast, len_err;
  logic [6:0]  waddr;
  logic [63:0] wdata;
  logic [15:0] blk_cnt;

  always #5 clk = ~clk;

  cpri_tx_gen dut (
    .clk(clk), .rst(rst), .i_tx_enable(tx_enable), .i_tvalid(tvalid), .o_tready(tready),
    .i_iq_tx_data(iq_data), .i_tlast(tlast), .i_hdr_info(hdr_info), .i_cpri_rdy(cpri_rdy),
    .o_cpri_wen(wen), .o_cpri_waddr(waddr), .o_cpri_wdata(wdata), .o_cpri_wlast(wlast),
    .o_blk_cnt(blk_cnt), .o_len_err(len_err)
  );

  // Model: accepted words queue up; a burst takes the oldest 96 words when it starts.
  logic [63:0] wq[$];
  logic [63:0] m_burst [99];
  int          m_pos = -1, m_full = 0, m_nacc = 0;
  logic [15:0] m_blk = 16'd0;
  logic        m_ready = 1'b1, m_len_err = 1'b0, m_acc;
  int          preset_tok = 0, seen_tok = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wq.delete();
      m_pos = -1; m_full = 0; m_nacc = 0; m_blk = 16'd0;
      m_ready = 1'b1; m_len_err = 1'b0; seen_tok = preset_tok;
    end else begin
      if (preset_tok != seen_tok) begin
        m_blk = 16'hFFFF;
        seen_tok = preset_tok;
      end
      m_acc = tvalid && m_ready;
      if (m_pos == 98) begin
        m_pos = -1; m_blk = m_blk + 16'd1; m_full = m_full - 1;
      end else if (m_pos >= 0) begin
        m_pos = m_pos + 1;
      end else if (tx_enable && cpri_rdy && m_full > 0) begin
        m_burst[0] = {SYNC, 16'd0, m_blk};
        m_burst[1] = {32'd0, hdr_info};
        m_burst[2] = 64'd0;
        for (int j = 0; j < 96; j++) m_burst[3+j] = wq.pop_front();
        m_pos = 0;
      end
      if (m_acc) begin
        wq.push_back(iq_data);
        m_len_err = (tlast != (m_nacc % 96 == 95));
        if (m_nacc % 96 == 95) m_full = m_full + 1;
        m_nacc = m_nacc + 1;
      end else begin
        m_len_err = 1'b0;
      end
      m_ready = (m_full < 2);
    end
  end

  int          total = 0, bad = 0;
  int          bursts = 0, cur_len = 0, last_len = 0, idle_run = 0, last_gap = 0;
  int          lerr_cnt = 0, wlast_cnt = 0, feed_target = 0;
  logic        prev_wen = 1'b0, seq_data = 1'b0, tlast50 = 1'b0, rand_hdr = 1'b0, rand_ctl = 1'b0;
  logic [63:0] cap [99];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    chk("wen", wen, m_pos >= 0);
    chk("wdata", wdata, (m_pos >= 0) ? m_burst[m_pos] : 64'd0);
    chk("wlast", wlast, m_pos == 98);
    chk("tready", tready, m_ready);
    chk("blk_cnt", blk_cnt, m_blk);
    chk("len_err", len_err, m_len_err);
    if (m_pos >= 0) chk("waddr", waddr, m_pos);
    if (wen && waddr < 7'd99) cap[waddr] = wdata;
    if (wlast) wlast_cnt++;
    if (len_err) lerr_cnt++;
    if (wen && !prev_wen) begin
      bursts++; last_gap = idle_run; cur_len = 0;
    end
    if (wen) begin
      cur_len++; idle_run = 0;
    end else begin
      idle_run++;
      if (prev_wen) last_len = cur_len;
    end
    prev_wen = wen;
  endtask

  task automatic drive();
    if (m_nacc < feed_target && $urandom_range(3) != 0) begin
      tvalid  = 1'b1;
      iq_data = seq_data ? 64'(m_nacc % 96) : {$urandom, $urandom};
      tlast   = (m_nacc % 96 == 95) || (tlast50 && m_nacc % 96 == 50);
    end else begin
      tvalid  = 1'b0;
      iq_data = {$urandom, $urandom};
      tlast   = 1'($urandom_range(1));
    end
    if (rand_hdr) hdr_info = $urandom;
    if (rand_ctl && $urandom_range(7) == 0) begin
      tx_enable = 1'($urandom_range(1));
      cpri_rdy  = 1'($urandom_range(1));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    drive();
  endtask

  task automatic run_until_idle_bursts(input int n, input int budget);
    int i = 0;
    while ((bursts < n || wen) && i < budget) begin
      tick(); i++;
    end
    chk("burst_wait", (bursts >= n) && !wen, 1);
  endtask

  task automatic run_until_addr(input logic [6:0] a, input int budget);
    int i = 0;
    while (!(wen && waddr == a) && i < budget) begin
      tick(); i++;
    end
    chk("addr_wait", wen && (waddr == a), 1);
  endtask

  initial begin
    int base, b0, l0, ok;
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_tready", tready, 1);
    chk("rst_wen", wen, 0);
    chk("rst_blk", blk_cnt, 0);
    chk("rst_len_err", len_err, 0);
    rst = 1'b0;

    // 1: single block with D=k, header info fixed
    tx_enable = 1'b1; cpri_rdy = 1'b1; hdr_info = 32'hABCD0001;
    seq_data = 1'b1; feed_target = 96;
    run_until_idle_bursts(1, 400);
    chk("t1_word0", cap[0], 64'h5A5AC3C3_0000_0000);
    chk("t1_word1", cap[1], 64'h0000_0000_ABCD0001);
    chk("t1_word2", cap[2], 64'd0);
    ok = 1;
    for (int k = 0; k < 96; k++) if (cap[3+k] !== 64'(k)) ok = 0;
    chk("t1_payload", ok, 1);
    chk("t1_blk", blk_cnt, 1);
    chk("t1_wlast_cnt", wlast_cnt, 1);
    chk("t1_len", last_len, 99);

    // 2: fill both banks with the link stalled, then release
    seq_data = 1'b0; rand_hdr = 1'b1; cpri_rdy = 1'b0;
    base = m_nacc; feed_target = base + 193;
    for (int i = 0; i < 800 && m_nacc < base + 192; i++) tick();
    repeat (20) tick();
    chk("t2_accepted", m_nacc - base, 192);
    chk("t2_tready_low", tready, 0);
    b0 = bursts; cpri_rdy = 1'b1;
    run_until_idle_bursts(b0 + 2, 400);
    chk("t2_gap", last_gap, 1);
    chk("t2_blk", blk_cnt, 3);

    // 3: drop enable and ready mid-burst
    feed_target = 96 * ((m_nacc + 95) / 96) + 96;
    run_until_addr(7'd10, 600);
    b0 = bursts; tx_enable = 1'b0; cpri_rdy = 1'b0;
    repeat (350) tick();
    chk("t3_hold", bursts, b0);
    chk("t3_full_pending", m_full, 1);
    tx_enable = 1'b1;
    repeat (20) tick();
    chk("t3_need_rdy", bursts, b0);
    cpri_rdy = 1'b1;
    run_until_idle_bursts(b0 + 1, 300);

    // 4: early tlast inside a block
    tlast50 = 1'b1; l0 = lerr_cnt; b0 = bursts;
    feed_target = m_nacc + 96;
    run_until_idle_bursts(b0 + 1, 500);
    chk("t4_len_err_pulses", lerr_cnt - l0, 1);
    tlast50 = 1'b0;

    // 5: asynchronous reset in the middle of a burst
    feed_target = m_nacc + 96;
    run_until_addr(7'd40, 500);
    #2 rst = 1'b1;
    #1;
    chk("t5_wen", wen, 0);
    chk("t5_wlast", wlast, 0);
    chk("t5_tready", tready, 1);
    chk("t5_blk", blk_cnt, 0);
    repeat (3) tick();
    rst = 1'b0; feed_target = 96; b0 = bursts;
    run_until_idle_bursts(b0 + 1, 500);
    chk("t5_word0", cap[0], 64'h5A5AC3C3_0000_0000);
    chk("t5_blk_after", blk_cnt, 1);

    // 6: counter wrap from FFFF
    tick();
    #2 force dut.blk_cnt = 16'hFFFF;
    preset_tok++;
    #1 release dut.blk_cnt;
    chk("t6_preset", blk_cnt, 16'hFFFF);
    b0 = bursts; feed_target = m_nacc + 96;
    run_until_idle_bursts(b0 + 1, 500);
    chk("t6_word0", cap[0], 64'h5A5AC3C3_0000_FFFF);
    chk("t6_wrap", blk_cnt, 0);

    // 7: random soak with enable/ready toggling
    rand_ctl = 1'b1; feed_target = m_nacc + 480;
    repeat (1500) tick();
    rand_ctl = 1'b0; tx_enable = 1'b1; cpri_rdy = 1'b1;
    for (int i = 0; i < 1500 && (m_nacc < feed_target || m_full > 0 || wen); i++) tick();
    chk("t7_drained", (m_full == 0) && !wen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
